cheese_spawner: RTL and testbench

CHEESE_SPAWNER -- requirements
Module: cheese_spawner

---
 rtl/game_pkg.sv | 36 +++
 rtl/pos_if.sv | 10 +
 rtl/cheese_lfsr.sv | 43 ++++
 rtl/cheese_spawner.sv | 152 +++++++++++++++
 tb/tb_cheese_spawner.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// game_pkg -- shared constants and types for the cheese spawner.
//   NUM_CHEESE_SPOTS          : default number of legal spawn spots
//   LFSR_MASK                 : Galois feedback mask of the spot LFSR
//   CHEESE_SPOT_X/_Y [16]     : 12-bit top-left spawn positions, each one
//                               sitting on a platform top
//   cheese_state_t            : spawner FSM states
//   lfsr_step()               : one Galois LFSR step
package game_pkg;

  localparam int NUM_CHEESE_SPOTS = 8;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam logic [11:0] CHEESE_SPOT_X [16] = '{
    12'd40,  12'd120, 12'd200, 12'd280, 12'd360, 12'd440, 12'd520, 12'd600,
    12'd80,  12'd160, 12'd240, 12'd320, 12'd400, 12'd480, 12'd560, 12'd640
  };

  localparam logic [11:0] CHEESE_SPOT_Y [16] = '{
    12'd400, 12'd336, 12'd272, 12'd208, 12'd144, 12'd400, 12'd336, 12'd272,
    12'd208, 12'd144, 12'd400, 12'd336, 12'd272, 12'd208, 12'd144, 12'd400
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PICK    = 2'd1,
    VISIBLE = 2'd2,
    HIDDEN  = 2'd3
  } cheese_state_t;

  // Right shift; when the bit shifted out is 1 the mask is folded back in.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/pos_if.sv
// pos_if -- 12-bit x/y screen position bundle.
//   x, y : top-left corner of the object in pixels
//   out  : producer side, in : consumer side
interface pos_if;
  logic [11:0] x;
  logic [11:0] y;

  modport out (output x, output y);
  modport in  (input x, input y);
endinterface

// File: rtl/cheese_lfsr.sv
// cheese_lfsr -- 16-bit Galois LFSR that picks cheese spawn spots.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset, loads seed
//   clr  : synchronous restart, loads seed while high
//   en   : advance one step per cycle while high
//   seed : non-zero reload value
//   q    : current LFSR value
// An all-zero value is a lock-up state of the LFSR, so it is replaced by
// the seed on the following cycle regardless of en.
module cheese_lfsr
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (lfsr_q == 16'h0000) begin
      lfsr_d = seed;
    end else if (en) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/cheese_spawner.sv
// cheese_spawner -- places the cheese at a pseudo-random platform spot,
// hides it for RESPAWN_DELAY cycles after it is taken, then respawns it.
//   clk             : rising-edge clock
//   rst             : synchronous active-low reset
//   reset           : game restart, active-high level, acts like rst
//   is_cheese_taken : one-cycle pulse from the take checker
//   cheesepos       : registered cheese top-left position (pos_if.out)
//   cheese_visible  : registered, high while cheese is drawn/collidable
//   spot_idx        : registered index of the current spot (upper bits 0)
//   dbg_state       : current FSM state (cheese_state_t encoding)
//   dbg_lfsr        : current LFSR value
// Optional feature: define CHEESE_NO_REPEAT_EN to forbid picking the same
// spot twice in a row (the index is bumped by one on a repeat).
//
// Handshake: is_cheese_taken has no ready/ack; a pulse is acted on only
// when sampled high in VISIBLE and ignored in every other state.
module cheese_spawner
  import game_pkg::*;
#(
  parameter int          NUM_SPOTS     = NUM_CHEESE_SPOTS,
  parameter int unsigned RESPAWN_DELAY = 65_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reset,
  input  logic       is_cheese_taken,
  pos_if.out         cheesepos,
  output logic       cheese_visible,
  output logic [3:0] spot_idx,
  output logic [1:0] dbg_state,
  output logic [15:0] dbg_lfsr
);

  localparam int IDX_W = $clog2(NUM_SPOTS);

  cheese_state_t state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          vis_q, vis_d;
  logic [11:0]   x_q, x_d;
  logic [11:0]   y_q, y_d;
  logic [3:0]    idx_q, idx_d;
  logic [15:0]   lfsr_q;
  logic [IDX_W-1:0] raw_idx;
  logic [IDX_W-1:0] pick_idx;
  logic [3:0]    pick_ext;

`ifdef CHEESE_NO_REPEAT_EN
  logic [IDX_W-1:0] prev_q, prev_d;
`endif

  // The LFSR free-runs whenever the game is not held in reset, so the
  // chosen spot depends on exactly when the player takes the cheese.
  cheese_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .clr  (reset),
    .en   (1'b1),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  always_comb begin
    raw_idx  = lfsr_q[IDX_W-1:0];
`ifdef CHEESE_NO_REPEAT_EN
    prev_d   = prev_q;
    pick_idx = (raw_idx == prev_q) ? IDX_W'(raw_idx + IDX_W'(1)) : raw_idx;
`else
    pick_idx = raw_idx;
`endif
    pick_ext = 4'(pick_idx);

    state_d = state_q;
    cnt_d   = cnt_q;
    vis_d   = vis_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        state_d = PICK;
      end
      PICK: begin
        // The only place position/index change; visibility rises with them.
        state_d = VISIBLE;
        x_d     = CHEESE_SPOT_X[pick_ext];
        y_d     = CHEESE_SPOT_Y[pick_ext];
        idx_d   = pick_ext;
        vis_d   = 1'b1;
`ifdef CHEESE_NO_REPEAT_EN
        prev_d  = pick_idx;
`endif
      end
      VISIBLE: begin
        if (is_cheese_taken) begin
          state_d = HIDDEN;
          vis_d   = 1'b0;
        end
      end
      HIDDEN: begin
        if (cnt_q == RESPAWN_DELAY - 32'd1) begin
          state_d = PICK;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || reset) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      vis_q   <= 1'b0;
      x_q     <= 12'd0;
      y_q     <= 12'd0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vis_q   <= vis_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
    end
  end

`ifdef CHEESE_NO_REPEAT_EN
  // Starts at the last index so the very first pick is never bumped
  // unless the LFSR itself lands on that last spot.
  always_ff @(posedge clk) begin
    if (!rst || reset) begin
      prev_q <= IDX_W'(NUM_SPOTS - 1);
    end else begin
      prev_q <= prev_d;
    end
  end
`endif

  assign cheesepos.x    = x_q;
  assign cheesepos.y    = y_q;
  assign cheese_visible = vis_q;
  assign spot_idx       = idx_q;
  assign dbg_state      = state_q;
  assign dbg_lfsr       = lfsr_q;

endmodule

// File: tb/tb_cheese_spawner.sv
// tb_cheese_spawner -- directed self-checking bench for cheese_spawner
// with RESPAWN_DELAY = 4. Compile with +define+CHEESE_NO_REPEAT_EN to
// enable the no-repeat checks.
module tb_cheese_spawner;

  localparam int          DELAY = 4;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [1:0]  S_IDLE = 2'd0, S_PICK = 2'd1, S_VIS = 2'd2, S_HID = 2'd3;

  // Expected spot table, written out independently of the design package.
  localparam logic [11:0] TX [8] = '{12'd40, 12'd120, 12'd200, 12'd280,
                                     12'd360, 12'd440, 12'd520, 12'd600};
  localparam logic [11:0] TY [8] = '{12'd400, 12'd336, 12'd272, 12'd208,
                                     12'd144, 12'd400, 12'd336, 12'd272};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic reset;
  logic taken;
  logic        cheese_visible;
  logic [3:0]  spot_idx;
  logic [1:0]  dbg_state;
  logic [15:0] dbg_lfsr;

  always #5 clk = ~clk;

  pos_if pos ();

  cheese_spawner #(
    .NUM_SPOTS     (8),
    .RESPAWN_DELAY (DELAY),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .reset           (reset),
    .is_cheese_taken (taken),
    .cheesepos       (pos),
    .cheese_visible  (cheese_visible),
    .spot_idx        (spot_idx),
    .dbg_state       (dbg_state),
    .dbg_lfsr        (dbg_lfsr)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0]  exp_q[$];
  logic [15:0] lfsr_m;
  logic [2:0]  prev_m;

  function automatic logic [15:0] model_step(input logic [15:0] v);
    logic [15:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge; the LFSR model follows the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (!rst || reset) begin
      lfsr_m = SEED;
      prev_m = 3'd7;
    end else begin
      lfsr_m = (lfsr_m == 16'h0000) ? SEED : model_step(lfsr_m);
    end
    @(negedge clk);
  endtask

  // Called while the DUT sits in PICK: predicts the spot, steps into VISIBLE.
  task automatic pick_and_check(input string tag);
    logic [2:0] e;
    logic [3:0] got_e;
    check_eq({tag, "_in_pick"}, dbg_state, S_PICK);
    e = lfsr_m[2:0];
`ifdef CHEESE_NO_REPEAT_EN
    if (e == prev_m) e = e + 3'd1;
    prev_m = e;
`endif
    exp_q.push_back({1'b0, e});
    tick();
    got_e = exp_q.pop_front();
    check_eq({tag, "_idx"}, spot_idx, got_e);
    check_eq({tag, "_x"}, pos.x, TX[got_e[2:0]]);
    check_eq({tag, "_y"}, pos.y, TY[got_e[2:0]]);
    check_eq({tag, "_vis"}, cheese_visible, 1'b1);
    check_eq({tag, "_st"}, dbg_state, S_VIS);
  endtask

  // Pulse (or hold) is_cheese_taken from VISIBLE; returns pulse-to-respawn cycles.
  task automatic take_cycle(input bit hold, output int lat);
    taken = 1'b1;
    tick();
    lat = 1;
    if (!hold) taken = 1'b0;
    check_eq("take_vis_fall", cheese_visible, 1'b0);
    check_eq("take_st_hidden", dbg_state, S_HID);
    while (dbg_state != S_PICK && lat < 20) begin
      tick();
      lat++;
    end
    taken = 1'b0;
    pick_and_check("respawn");
    lat++;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [3:0] last_idx;
    logic [7:0] seen;
    rst = 1'b0; reset = 1'b0; taken = 1'b0;
    lfsr_m = SEED; prev_m = 3'd7;
    @(negedge clk);
    repeat (3) tick();

    // Held in reset.
    check_eq("rst_state", dbg_state, S_IDLE);
    check_eq("rst_vis", cheese_visible, 1'b0);
    check_eq("rst_x", pos.x, 12'd0);
    check_eq("rst_y", pos.y, 12'd0);
    check_eq("rst_idx", spot_idx, 4'd0);
    check_eq("rst_lfsr", dbg_lfsr, SEED);

    // Release: IDLE -> PICK after one edge, VISIBLE after two.
    rst = 1'b1;
    tick();
    check_eq("rel_pick_vis_low", cheese_visible, 1'b0);
    pick_and_check("first");
    // ACE1 -> E270 after one step, low three bits 0.
    check_eq("first_idx_hand", spot_idx, 4'd0);
    check_eq("first_x_hand", pos.x, 12'd40);

    // Cheese stays put while not taken.
    repeat (3) tick();
    check_eq("idle_vis_hold", cheese_visible, 1'b1);
    check_eq("idle_idx_hold", spot_idx, 4'd0);

    // Single take pulse.
    take_cycle(1'b0, lat);
    check_eq("take_latency", lat, DELAY + 2);

    // Pulse held high throughout HIDDEN.
    take_cycle(1'b1, lat);
    check_eq("spurious_latency", lat, DELAY + 2);

    // Restart in HIDDEN with the delay counter at 2.
    taken = 1'b1;
    tick();
    taken = 1'b0;
    tick();
    tick();
    check_eq("pre_restart_st", dbg_state, S_HID);
    reset = 1'b1;
    tick();
    check_eq("restart_state", dbg_state, S_IDLE);
    check_eq("restart_vis", cheese_visible, 1'b0);
    check_eq("restart_x", pos.x, 12'd0);
    check_eq("restart_y", pos.y, 12'd0);
    check_eq("restart_idx", spot_idx, 4'd0);
    check_eq("restart_lfsr", dbg_lfsr, SEED);
    reset = 1'b0;
    tick();
    pick_and_check("after_restart");
    check_eq("restart_same_first", spot_idx, 4'd0);
    take_cycle(1'b0, lat);
    check_eq("restart_take_latency", lat, DELAY + 2);

    // Long run of takes at varying player timing.
    last_idx = spot_idx;
    seen = 8'h00;
    seen[last_idx[2:0]] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      repeat (i % 4) tick();
      take_cycle(1'b0, lat);
      check_eq("loop_latency", lat, DELAY + 2);
`ifdef CHEESE_NO_REPEAT_EN
      n_tests++;
      if (spot_idx == last_idx) begin
        n_fail++;
        $display("FAIL norepeat: got %0d expected not %0d", spot_idx, last_idx);
      end
`endif
      last_idx = spot_idx;
      seen[spot_idx[2:0]] = 1'b1;
    end
`ifdef CHEESE_NO_REPEAT_EN
    check_eq("all_spots_seen", seen, 8'hFF);
`endif

    // LFSR lock-up recovery.
    force dut.u_lfsr.lfsr_q = 16'h0000;
    #1;
    check_eq("lfsr_forced_zero", dbg_lfsr, 16'h0000);
    release dut.u_lfsr.lfsr_q;
    lfsr_m = 16'h0000;
    tick();
    check_eq("lfsr_zero_recover", dbg_lfsr, 16'hACE1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
